// File: rtl/pool_window_feeder_pkg.sv
// Shared definitions for the 3x3 max-pool window feeder and the pool engine.
//   DATA_W   : pixel width (FP16)
//   TAPS     : pixels per 3x3 window
//   WIN_W    : width of the packed window bus
//   state_t  : feeder sequencer states
//   put_slot : writes one pixel into slot k (bits [16k+15:16k]) of a window bus
package pool_window_feeder_pkg;

  localparam int DATA_W = 16;
  localparam int TAPS   = 9;
  localparam int WIN_W  = TAPS * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Slot k = r*3 + c lives at bits [DATA_W*k +: DATA_W]. Constant slot
  // indices keep the select static for synthesis.
  function automatic logic [WIN_W-1:0] put_slot(input logic [WIN_W-1:0]  win,
                                                input logic [3:0]        k,
                                                input logic [DATA_W-1:0] pix);
    logic [WIN_W-1:0] res;
    res = win;
    for (int s = 0; s < TAPS; s++) begin
      if (k == 4'(s)) res[s*DATA_W +: DATA_W] = pix;
    end
    return res;
  endfunction

endpackage

// File: rtl/pool_window_feeder_addr_gen.sv
// pool_addr_gen: window/tap counters and incremental address arithmetic.
//   load        : capture pass configuration and clear all counters
//   tap_step    : advance to the next tap (c inner, r outer)
//   win_step    : advance to the next output window (ox inner, oy outer)
//   wr_step     : advance the output write index
//   rd_addr     : src_base + row_base + r*in_w + col_base + c
//   wr_addr     : dst_base + out_idx
//   last_tap    : current tap is (r=2, c=2)
//   last_window : current window is the bottom-right one of the pass
module pool_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [DIM_W-1:0]  in_h,
  input  logic              stride,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              tap_step,
  input  logic              win_step,
  input  logic              wr_step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_tap,
  output logic              last_window
);

  logic [ADDR_W-1:0] src_q, dst_q, in_w_q, col_inc_q, row_inc_q;
  logic [DIM_W-1:0]  out_w_q, out_h_q, ox_q, oy_q;
  logic [1:0]        r_q, c_q;
  logic [ADDR_W-1:0] r_off_q, col_base_q, row_base_q, out_idx_q;
  logic [ADDR_W-1:0] w_ext;
  logic              last_ox;

  // Output dimension; only meaningful when d >= 3 (the top rejects smaller maps).
  function automatic logic [DIM_W-1:0] out_dim(input logic [DIM_W-1:0] d, input logic s);
    logic [DIM_W-1:0] span;
    span = d - DIM_W'(3);
    return (s ? (span >> 1) : span) + DIM_W'(1);
  endfunction

  assign w_ext       = ADDR_W'(in_w);
  assign last_tap    = (r_q == 2'd2) && (c_q == 2'd2);
  assign last_ox     = (ox_q == out_w_q - DIM_W'(1));
  assign last_window = last_ox && (oy_q == out_h_q - DIM_W'(1));
  assign rd_addr     = src_q + row_base_q + col_base_q + r_off_q + ADDR_W'(c_q);
  assign wr_addr     = dst_q + out_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      in_w_q     <= '0;
      col_inc_q  <= '0;
      row_inc_q  <= '0;
      out_w_q    <= '0;
      out_h_q    <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      r_off_q    <= '0;
      col_base_q <= '0;
      row_base_q <= '0;
      out_idx_q  <= '0;
    end else if (load) begin
      src_q      <= src_base;
      dst_q      <= dst_base;
      in_w_q     <= w_ext;
      col_inc_q  <= stride ? ADDR_W'(2) : ADDR_W'(1);
      row_inc_q  <= stride ? (w_ext << 1) : w_ext;
      out_w_q    <= out_dim(in_w, stride);
      out_h_q    <= out_dim(in_h, stride);
      ox_q       <= '0;
      oy_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      r_off_q    <= '0;
      col_base_q <= '0;
      row_base_q <= '0;
      out_idx_q  <= '0;
    end else begin
      if (tap_step) begin
        if (c_q == 2'd2) begin
          c_q <= '0;
          if (r_q == 2'd2) begin
            r_q     <= '0;
            r_off_q <= '0;
          end else begin
            r_q     <= r_q + 2'd1;
            r_off_q <= r_off_q + in_w_q;
          end
        end else begin
          c_q <= c_q + 2'd1;
        end
      end
      if (win_step) begin
        if (last_ox) begin
          ox_q       <= '0;
          col_base_q <= '0;
          oy_q       <= oy_q + DIM_W'(1);
          row_base_q <= row_base_q + row_inc_q;
        end else begin
          ox_q       <= ox_q + DIM_W'(1);
          col_base_q <= col_base_q + col_inc_q;
        end
      end
      if (wr_step) out_idx_q <= out_idx_q + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: reads 3x3 windows of one FP16 feature-map channel,
// hands each window to the max-pool engine and writes the pooled results.
//   start/in_w/in_h/stride/src_base/dst_base : pass request, sampled in IDLE
//   rd_en/rd_addr/rd_data : input buffer read port (data 1 cycle after rd_en)
//   im/pool_ready         : window bus and one-cycle issue pulse
//   pool_valid/om         : pool result (rising edge of pool_valid accepted)
//   wr_en/wr_addr/wr_data : output buffer write port
//   busy/done/err         : pass status; err is a sticky bad-config flag
module pool_window_feeder #(
  parameter int DATA_W = pool_window_feeder_pkg::DATA_W,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIM_W-1:0]    in_w,
  input  logic [DIM_W-1:0]    in_h,
  input  logic                stride,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [ADDR_W-1:0]   dst_base,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [9*DATA_W-1:0] im,
  output logic                pool_ready,
  input  logic                pool_valid,
  input  logic [DATA_W-1:0]   om,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import pool_window_feeder_pkg::*;

  state_t              state_q, state_d;
  logic                load, tap_step, win_step, wr_step;
  logic                last_tap, last_window;
  logic                pool_valid_q, pv_rise;
  logic                cap_en_q;
  logic [3:0]          cap_slot_q;
  logic [9*DATA_W-1:0] win_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                err_q;
  logic                bad_cfg, accept;

  assign bad_cfg = (in_w < DIM_W'(3)) || (in_h < DIM_W'(3));
  assign accept  = (state_q == S_IDLE) && start;
  // Only a fresh 0->1 edge counts, so a level left high from the previous
  // window cannot complete the current one.
  assign pv_rise = pool_valid && !pool_valid_q;

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .in_w        (in_w),
    .in_h        (in_h),
    .stride      (stride),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .tap_step    (tap_step),
    .win_step    (win_step),
    .wr_step     (wr_step),
    .rd_addr     (rd_addr),
    .wr_addr     (wr_addr),
    .last_tap    (last_tap),
    .last_window (last_window)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    tap_step = 1'b0;
    win_step = 1'b0;
    wr_step  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_cfg) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            load    = 1'b1;
          end
        end
      end
      S_FETCH: begin
        tap_step = 1'b1;
        if (last_tap) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (pv_rise) state_d = S_WRITE;
      S_WRITE: begin
        wr_step = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        win_step = 1'b1;
        state_d  = last_window ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pool_valid_q <= 1'b0;
      cap_en_q     <= 1'b0;
      cap_slot_q   <= '0;
      // NOTE: the window register is a flop bank, not a RAM, and the bus is
      // required to read zero out of reset, so it takes the async reset.
      win_q        <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pool_valid_q <= pool_valid;
      // rd_data lags rd_en by one cycle; the delayed strobe marks valid data.
      cap_en_q     <= rd_en;
      if (accept) err_q <= bad_cfg;
      if (load) begin
        cap_slot_q <= '0;
      end else if (cap_en_q) begin
        win_q      <= put_slot(win_q, cap_slot_q, rd_data);
        cap_slot_q <= (cap_slot_q == 4'd8) ? 4'd0 : cap_slot_q + 4'd1;
      end
      if ((state_q == S_WAIT) && pv_rise) wr_data_q <= om;
    end
  end

  assign rd_en      = (state_q == S_FETCH);
  assign pool_ready = (state_q == S_ISSUE);
  assign wr_en      = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign im         = win_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed self-checking bench for pool_window_feeder: buffer memory model,
// max-pool model with 3-cycle latency (overridable by hand), write logger.
`timescale 1ns/1ps
module tb_pool_window_feeder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DIM_W  = 7;

  logic                clk = 1'b0;
  logic                rst_n, start, stride;
  logic [DIM_W-1:0]    in_w, in_h;
  logic [ADDR_W-1:0]   src_base, dst_base;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [9*DATA_W-1:0] im;
  logic                pool_ready, pool_valid;
  logic [DATA_W-1:0]   om;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                busy, done, err;

  always #5 clk = ~clk;

  pool_window_feeder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_w       (in_w),
    .in_h       (in_h),
    .stride     (stride),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .im         (im),
    .pool_ready (pool_ready),
    .pool_valid (pool_valid),
    .om         (om),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Input buffer: registered read, data valid the cycle after rd_en.
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Pool model: max over the window, valid pulses 3 cycles after issue.
  int                lat_cnt;
  logic              auto_valid;
  logic [DATA_W-1:0] auto_om;
  logic              man_mode, man_valid;
  logic [DATA_W-1:0] man_om;

  assign pool_valid = man_mode ? man_valid : auto_valid;
  assign om         = man_mode ? man_om : auto_om;

  function automatic logic [DATA_W-1:0] window_max(input logic [9*DATA_W-1:0] w);
    logic [9*DATA_W-1:0] t;
    logic [DATA_W-1:0]   m;
    t = w;
    m = '0;
    for (int k = 0; k < 9; k++) begin
      if (t[DATA_W-1:0] > m) m = t[DATA_W-1:0];
      t = t >> DATA_W;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      lat_cnt    <= 0;
      auto_valid <= 1'b0;
      auto_om    <= '0;
    end else begin
      auto_valid <= 1'b0;
      if (pool_ready) begin
        lat_cnt <= 3;
        auto_om <= window_max(im);
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) auto_valid <= 1'b1;
      end
    end
  end

  // Activity logger.
  int                rd_total = 0;
  int                wr_total = 0;
  logic [DATA_W-1:0] wr_data_log [0:63];
  logic [ADDR_W-1:0] wr_addr_log [0:63];
  always @(posedge clk) begin
    if (rd_en) rd_total <= rd_total + 1;
    if (wr_en) begin
      wr_data_log[wr_total[5:0]] <= wr_data;
      wr_addr_log[wr_total[5:0]] <= wr_addr;
      wr_total <= wr_total + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after start was sampled.
  task automatic pulse_start(input int w, input int h, input bit s, input int src, input int dst);
    in_w     = DIM_W'(w);
    in_h     = DIM_W'(h);
    stride   = s;
    src_base = ADDR_W'(src);
    dst_base = ADDR_W'(dst);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (pool_ready) seen = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic busy_at);
    seen    = 1'b0;
    busy_at = 1'bx;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) begin
        seen    = 1'b1;
        busy_at = busy;
      end
    end
  endtask

  task automatic check_writes(input string tag, input int base, input int dst,
                              input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                              input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3);
    logic [DATA_W-1:0] e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_wr_count"}, 144'(wr_total - base), 144'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_wr_data%0d", tag, i), 144'(wr_data_log[6'(base + i)]), 144'(e[i]));
      check($sformatf("%s_wr_addr%0d", tag, i), 144'(wr_addr_log[6'(base + i)]), 144'(ADDR_W'(dst + i)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_im"}, 144'(im), 144'(0));
    check({tag, "_ctl"}, 144'({rd_en, rd_addr, pool_ready, wr_en, wr_addr, wr_data, busy, done, err}),
          144'(0));
  endtask

  initial begin
    bit                seen;
    logic              busy_at;
    int                rd0, wr0;
    logic [143:0]      exp_im;

    rst_n = 1'b0; start = 1'b0; stride = 1'b0;
    in_w = '0; in_h = '0; src_base = '0; dst_base = '0;
    man_mode = 1'b0; man_valid = 1'b0; man_om = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[100 + i] = DATA_W'(i);
    for (int i = 0; i < 25; i++) mem[300 + i] = DATA_W'(i);

    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 4x4 map 0..15, stride 1.
    rd0 = rd_total; wr0 = wr_total;
    pulse_start(4, 4, 1'b0, 100, 200);
    check("t1_first_rd_en", 144'(rd_en), 144'(1));
    check("t1_first_rd_addr", 144'(rd_addr), 144'(100));
    check("t1_busy", 144'(busy), 144'(1));
    wait_ready(30, seen);
    check("t1_ready_seen", 144'(seen), 144'(1));
    exp_im = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
    check("t1_first_window", im, exp_im);
    wait_done(200, seen, busy_at);
    check("t1_done_seen", 144'(seen), 144'(1));
    check("t1_busy_at_done", 144'(busy_at), 144'(0));
    check_writes("t1", wr0, 200, 16'd10, 16'd11, 16'd14, 16'd15);
    check("t1_rd_count", 144'(rd_total - rd0), 144'(36));
    tick();
    check("t1_done_pulse_end", 144'(done), 144'(0));

    // 5x5 map 0..24, stride 2.
    rd0 = rd_total; wr0 = wr_total;
    pulse_start(5, 5, 1'b1, 300, 400);
    wait_done(200, seen, busy_at);
    check("t2_done_seen", 144'(seen), 144'(1));
    check_writes("t2", wr0, 400, 16'd12, 16'd14, 16'd22, 16'd24);
    check("t2_rd_count", 144'(rd_total - rd0), 144'(36));
    tick();

    // Bad config: width 2.
    rd0 = rd_total; wr0 = wr_total;
    pulse_start(2, 5, 1'b0, 100, 200);
    check("t3_done", 144'(done), 144'(1));
    check("t3_err", 144'(err), 144'(1));
    check("t3_busy", 144'(busy), 144'(0));
    tick();
    check("t3_done_end", 144'(done), 144'(0));
    check("t3_err_sticky", 144'(err), 144'(1));
    check("t3_no_rd", 144'(rd_total - rd0), 144'(0));
    check("t3_no_wr", 144'(wr_total - wr0), 144'(0));

    // pool_valid held high across issue: only a fresh rise is accepted.
    wr0 = wr_total;
    man_mode = 1'b1; man_valid = 1'b1; man_om = 16'h0AAA;
    pulse_start(3, 3, 1'b0, 100, 600);
    check("t4_err_cleared", 144'(err), 144'(0));
    wait_ready(30, seen);
    check("t4_ready_seen", 144'(seen), 144'(1));
    for (int i = 0; i < 6; i++) tick();
    check("t4_no_write_on_level", 144'(wr_total - wr0), 144'(0));
    man_valid = 1'b0;
    tick(); tick();
    man_om = 16'h1234; man_valid = 1'b1;
    wait_done(30, seen, busy_at);
    check("t4_done_seen", 144'(seen), 144'(1));
    check("t4_wr_count", 144'(wr_total - wr0), 144'(1));
    check("t4_wr_data", 144'(wr_data_log[6'(wr0)]), 144'(16'h1234));
    check("t4_wr_addr", 144'(wr_addr_log[6'(wr0)]), 144'(600));
    man_mode = 1'b0; man_valid = 1'b0;
    tick();

    // start while waiting on the pool engine is ignored.
    rd0 = rd_total; wr0 = wr_total;
    pulse_start(4, 4, 1'b0, 100, 200);
    wait_ready(30, seen);
    check("t5_ready_seen", 144'(seen), 144'(1));
    tick();
    in_w = DIM_W'(9); in_h = DIM_W'(9); src_base = '0; dst_base = ADDR_W'(500);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_kept", 144'(busy), 144'(1));
    wait_done(200, seen, busy_at);
    check("t5_done_seen", 144'(seen), 144'(1));
    check_writes("t5", wr0, 200, 16'd10, 16'd11, 16'd14, 16'd15);
    check("t5_rd_count", 144'(rd_total - rd0), 144'(36));
    tick();

    // Reset in the 5th FETCH cycle, then a clean pass.
    pulse_start(4, 4, 1'b0, 100, 200);
    for (int i = 0; i < 4; i++) tick();
    check("t6_fetch5_rd_en", 144'(rd_en), 144'(1));
    check("t6_fetch5_rd_addr", 144'(rd_addr), 144'(105));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    tick();
    check_reset_outputs("t6_next");
    rst_n = 1'b1;
    tick();
    rd0 = rd_total; wr0 = wr_total;
    pulse_start(5, 5, 1'b1, 300, 400);
    wait_done(200, seen, busy_at);
    check("t6_done_seen", 144'(seen), 144'(1));
    check_writes("t6", wr0, 400, 16'd12, 16'd14, 16'd22, 16'd24);
    check("t6_rd_count", 144'(rd_total - rd0), 144'(36));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Sequencer that feeds the 3x3 max-pool engine. It reads FP16 pixels of one feature-map channel from an on-chip buffer read port, assembles each 3x3 window into the 144-bit window bus, and handshakes it to the pool engine. It captures each pooled result and writes it to an output buffer write port. It sits between the feature-map BRAM and the pool engine, replacing hand-driven window loading.

## Interface
Parameters:
- DATA_W, 16, pixel width (FP16)
- ADDR_W, 12, buffer address width
- DIM_W, 7, width of map dimension fields (max 127)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that begins a pass; ignored unless IDLE
- in_w, in_h  in  DIM_W  input map width/height; sampled at start
- stride  in  1  0 means stride 1, 1 means stride 2; sampled at start
- src_base, dst_base  in  ADDR_W  input/output base addresses; sampled at start
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  DATA_W  read data; valid exactly 1 cycle after rd_en
- im  out  9*DATA_W  window bus; slot k=r*3+c at bits [16k+15:16k]
- pool_ready  out  1  one-cycle window-issue pulse
- pool_valid  in  1  pool-engine result flag (level)
- om  in  DATA_W  pooled result
- wr_en  out  1  output write strobe
- wr_addr  out  ADDR_W  output address
- wr_data  out  DATA_W  output data
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky bad-config flag; cleared by next accepted start

## Operation
- Output dims: out_w = (in_w-3)>>stride + 1, out_h = (in_h-3)>>stride + 1. Integer truncation; trailing columns/rows not covered are dropped.
- Config check at start: if in_w<3 or in_h<3, set err, pulse done next cycle, and perform no reads or writes.
- States:
  - IDLE: on start, go to FETCH.
  - FETCH: 9 consecutive rd_en cycles, r outer, c inner. Address = src_base + row_base + r*in_w + col_base + c, computed with incremental adders (no multiplier).
  - DRAIN: 1 cycle to capture the last rd_data.
  - ISSUE: pool_ready=1 for 1 cycle.
  - WAIT: wait for a 0→1 transition of pool_valid, using a registered pool_valid_q. A level held high from a previous window is not accepted.
  - WRITE: wr_en=1, wr_data=om, wr_addr=dst_base+out_idx.
  - NEXT: ox++. On ox==out_w-1, wrap ox to 0 and increment oy. After the last window, go to DONE; otherwise go to FETCH.
  - DONE: done=1, then IDLE.
- col_base advances by 1<<stride per ox. row_base advances by in_w<<stride per oy.
- out_idx increments by 1 per write, giving row-major output.
- im slots hold their value from capture until the next FETCH overwrites them.

## Timing
- Reset values: rd_en=0, rd_addr=0, im=0, pool_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. State is IDLE, all counters 0.
- Per-window cycles: 9 (FETCH) + 1 (DRAIN) + 1 (ISSUE) + L_pool + 1 (WRITE) + 1 (NEXT), where L_pool is the number of cycles from pool_ready to pool_valid rising, detected 1 cycle later.
- The first rd_en occurs 1 cycle after start is sampled.
- busy rises the cycle after start and falls in the same cycle done pulses.
- start while busy: ignored, with no effect on config or counters.
- pool_valid never rises: the block stays in WAIT indefinitely (no timeout); upstream must reset.
- rst_n asserted mid-pass: immediate return to reset values. There is no partial-write guarantee and no done pulse.

## Structure
- Shared package: DATA_W, the state encoding constants, and the slot-packing macro/function (slot k → bits [16k+15:16k]), shared with the pool engine.
- Sub-module: pool_addr_gen, which holds the ox/oy/r/c counters and incremental address arithmetic and exposes rd_addr, wr_addr, last_tap, and last_window. The top level keeps the FSM, window registers, and handshake.

## Test plan
- 4x4 map of values 0..15, stride 1, pool model with 3-cycle latency → 4 writes: 10, 11, 14, 15 at dst_base+0..3, then done.
- 5x5 map of values 0..24, stride 2 → 4 writes: 12, 14, 22, 24.
- in_w=2, in_h=5, start → err=1, done 1 cycle later, rd_en and wr_en never asserted.
- pool_valid held at 1 from before ISSUE → no write until pool_valid drops and rises again; the written value equals om at that rise.
- start pulsed during WAIT with in_w=9 → ignored; the pass completes using the original config and write count.
- rst_n low in the 5th FETCH cycle → next cycle all outputs at reset values. A fresh start then completes normally with correct results.
